// File: rtl/dot_prod_acc_pip.sv
// Pipelined complex dot product: x*y or x*conj(y), accumulated over LENGTH beats per frame,
// with one full-precision sum per frame presented under ready/valid backpressure.
module dot_prod_acc_pip #(
   parameter int XI_BITS    = 12,
   parameter int XQ_BITS    = 12,
   parameter int YI_BITS    = 12,
   parameter int YQ_BITS    = 12,
   parameter int LENGTH     = 64,
   parameter int SUM_I_SIZE = XI_BITS + YI_BITS + 1 + $clog2(LENGTH),
   parameter int SUM_Q_SIZE = XQ_BITS + YQ_BITS + 1 + $clog2(LENGTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         conj_y,
   input  logic                         m_axis_x_tvalid,
   output logic                         m_axis_x_tready,
   input  logic signed [XI_BITS-1:0]    xi,
   input  logic signed [XQ_BITS-1:0]    xq,
   input  logic                         m_axis_y_tvalid,
   output logic                         m_axis_y_tready,
   input  logic signed [YI_BITS-1:0]    yi,
   input  logic signed [YQ_BITS-1:0]    yq,
   input  logic                         m_axis_product_tready,
   output logic                         s_axis_product_tvalid,
   output logic signed [SUM_I_SIZE-1:0] i,
   output logic signed [SUM_Q_SIZE-1:0] q
);

   localparam int PII_W = XI_BITS + YI_BITS;
   localparam int PQQ_W = XQ_BITS + YQ_BITS;
   localparam int PIQ_W = XI_BITS + YQ_BITS;
   localparam int PQI_W = XQ_BITS + YI_BITS;
   localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

   logic en, beat, first_beat, last_beat, conj_cur;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic conj_q;

   logic s1_v_q, s1_first_q, s1_last_q, s1_conj_q;
   logic signed [XI_BITS-1:0] s1_xi_q;
   logic signed [XQ_BITS-1:0] s1_xq_q;
   logic signed [YI_BITS-1:0] s1_yi_q;
   logic signed [YQ_BITS-1:0] s1_yq_q;

   logic s2_v_q, s2_first_q, s2_last_q, s2_conj_q;
   logic signed [PII_W-1:0] s2_pii_q;
   logic signed [PQQ_W-1:0] s2_pqq_q;
   logic signed [PIQ_W-1:0] s2_piq_q;
   logic signed [PQI_W-1:0] s2_pqi_q;

   logic s3_v_q, s3_first_q, s3_last_q;
   logic signed [SUM_I_SIZE-1:0] s3_ti_q, s3_ti_d;
   logic signed [SUM_Q_SIZE-1:0] s3_tq_q, s3_tq_d;

   logic s4_v_q, s4_last_q;
   logic signed [SUM_I_SIZE-1:0] acc_re_q, acc_re_d;
   logic signed [SUM_Q_SIZE-1:0] acc_im_q, acc_im_d;

   logic out_v_q;
   logic signed [SUM_I_SIZE-1:0] sum_i_q;
   logic signed [SUM_Q_SIZE-1:0] sum_q_q;

   // The whole pipeline freezes only while a finished sum waits for downstream.
   assign en              = !(out_v_q && !m_axis_product_tready);
   assign beat            = m_axis_x_tvalid && m_axis_y_tvalid && en;
   assign m_axis_x_tready = en;
   assign m_axis_y_tready = en;

   assign first_beat = (cnt_q == '0);
   assign last_beat  = (cnt_q == LAST_CNT);
   assign conj_cur   = first_beat ? conj_y : conj_q;

   always_comb begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         conj_q <= 1'b0;
      end else if (beat) begin
         cnt_q <= cnt_d;
         if (first_beat) conj_q <= conj_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q     <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_conj_q  <= 1'b0;
         s1_xi_q    <= '0;
         s1_xq_q    <= '0;
         s1_yi_q    <= '0;
         s1_yq_q    <= '0;
      end else if (en) begin
         s1_v_q     <= beat;
         s1_first_q <= first_beat;
         s1_last_q  <= last_beat;
         s1_conj_q  <= conj_cur;
         s1_xi_q    <= xi;
         s1_xq_q    <= xq;
         s1_yi_q    <= yi;
         s1_yq_q    <= yq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q     <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_conj_q  <= 1'b0;
         s2_pii_q   <= '0;
         s2_pqq_q   <= '0;
         s2_piq_q   <= '0;
         s2_pqi_q   <= '0;
      end else if (en) begin
         s2_v_q     <= s1_v_q;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         s2_conj_q  <= s1_conj_q;
         s2_pii_q   <= PII_W'(s1_xi_q) * PII_W'(s1_yi_q);
         s2_pqq_q   <= PQQ_W'(s1_xq_q) * PQQ_W'(s1_yq_q);
         s2_piq_q   <= PIQ_W'(s1_xi_q) * PIQ_W'(s1_yq_q);
         s2_pqi_q   <= PQI_W'(s1_xq_q) * PQI_W'(s1_yi_q);
      end
   end

   always_comb begin
      s3_ti_d = '0;
      s3_tq_d = '0;
      if (s2_conj_q) begin
         s3_ti_d = SUM_I_SIZE'(s2_pii_q) + SUM_I_SIZE'(s2_pqq_q);
         s3_tq_d = SUM_Q_SIZE'(s2_pqi_q) - SUM_Q_SIZE'(s2_piq_q);
      end else begin
         s3_ti_d = SUM_I_SIZE'(s2_pii_q) - SUM_I_SIZE'(s2_pqq_q);
         s3_tq_d = SUM_Q_SIZE'(s2_piq_q) + SUM_Q_SIZE'(s2_pqi_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v_q     <= 1'b0;
         s3_first_q <= 1'b0;
         s3_last_q  <= 1'b0;
         s3_ti_q    <= '0;
         s3_tq_q    <= '0;
      end else if (en) begin
         s3_v_q     <= s2_v_q;
         s3_first_q <= s2_first_q;
         s3_last_q  <= s2_last_q;
         s3_ti_q    <= s3_ti_d;
         s3_tq_q    <= s3_tq_d;
      end
   end

   // A first beat reloads the accumulator, so no partial sum leaks across frames.
   always_comb begin
      acc_re_d = s3_first_q ? s3_ti_q : acc_re_q + s3_ti_q;
      acc_im_d = s3_first_q ? s3_tq_q : acc_im_q + s3_tq_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s4_v_q    <= 1'b0;
         s4_last_q <= 1'b0;
         acc_re_q  <= '0;
         acc_im_q  <= '0;
      end else if (en) begin
         s4_v_q    <= s3_v_q;
         s4_last_q <= s3_last_q;
         if (s3_v_q) begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
         end
      end
   end

   // A new frame total may load on the same edge the previous one is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v_q <= 1'b0;
         sum_i_q <= '0;
         sum_q_q <= '0;
      end else if (en && s4_v_q && s4_last_q) begin
         out_v_q <= 1'b1;
         sum_i_q <= acc_re_q;
         sum_q_q <= acc_im_q;
      end else if (out_v_q && m_axis_product_tready) begin
         out_v_q <= 1'b0;
      end
   end

   assign s_axis_product_tvalid = out_v_q;
   assign i                     = sum_i_q;
   assign q                     = sum_q_q;

endmodule

// File: tb/tb_dot_prod_acc_pip.sv
// Bench for dot_prod_acc_pip: three instances (LENGTH 4, 64, 1) sharing data inputs,
// checked against a frame-level arithmetic model of x*y / x*conj(y) sums.
module tb_dot_prod_acc_pip;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic conj;
   logic signed [11:0] xi_s, xq_s, yi_s, yq_s;
   logic [2:0] xv, yv, ptr, xrdy, yrdy, tv;
   logic signed [26:0] i0, q0;
   logic signed [30:0] i1, q1;
   logic signed [24:0] i2, q2;
   longint oi [3];
   longint oq [3];

   int tests = 0;
   int fails = 0;

   int     cnt [3];
   bit     cf  [3];
   longint ai  [3];
   longint aq  [3];
   longint eqi [3][64];
   longint eqq [3][64];
   int     wp  [3];
   int     rp  [3];

   dot_prod_acc_pip #(.LENGTH(4)) u_len4 (
      .clk(clk), .rst_n(rst_n), .conj_y(conj),
      .m_axis_x_tvalid(xv[0]), .m_axis_x_tready(xrdy[0]), .xi(xi_s), .xq(xq_s),
      .m_axis_y_tvalid(yv[0]), .m_axis_y_tready(yrdy[0]), .yi(yi_s), .yq(yq_s),
      .m_axis_product_tready(ptr[0]), .s_axis_product_tvalid(tv[0]), .i(i0), .q(q0));

   dot_prod_acc_pip #(.LENGTH(64)) u_len64 (
      .clk(clk), .rst_n(rst_n), .conj_y(conj),
      .m_axis_x_tvalid(xv[1]), .m_axis_x_tready(xrdy[1]), .xi(xi_s), .xq(xq_s),
      .m_axis_y_tvalid(yv[1]), .m_axis_y_tready(yrdy[1]), .yi(yi_s), .yq(yq_s),
      .m_axis_product_tready(ptr[1]), .s_axis_product_tvalid(tv[1]), .i(i1), .q(q1));

   dot_prod_acc_pip #(.LENGTH(1)) u_len1 (
      .clk(clk), .rst_n(rst_n), .conj_y(conj),
      .m_axis_x_tvalid(xv[2]), .m_axis_x_tready(xrdy[2]), .xi(xi_s), .xq(xq_s),
      .m_axis_y_tvalid(yv[2]), .m_axis_y_tready(yrdy[2]), .yi(yi_s), .yq(yq_s),
      .m_axis_product_tready(ptr[2]), .s_axis_product_tvalid(tv[2]), .i(i2), .q(q2));

   always_comb begin
      oi[0] = longint'(i0);
      oq[0] = longint'(q0);
      oi[1] = longint'(i1);
      oq[1] = longint'(q1);
      oi[2] = longint'(i2);
      oq[2] = longint'(q2);
   end

   function automatic int len_of(input int k);
      case (k)
         0:       return 4;
         1:       return 64;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: sees every handshake between edges and queues each frame total.
   always @(negedge clk) begin : model
      longint a, b, c, d, ti, tq;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            cnt[k] = 0;
            ai[k]  = 0;
            aq[k]  = 0;
            wp[k]  = 0;
            rp[k]  = 0;
         end else begin
            if (tv[k] && ptr[k]) begin
               if (rp[k] == wp[k]) begin
                  check($sformatf("unexpected_result_%0d", k), longint'(wp[k] - rp[k]), 1);
               end else begin
                  check($sformatf("sum_i_len%0d", len_of(k)), oi[k], eqi[k][rp[k] % 64]);
                  check($sformatf("sum_q_len%0d", len_of(k)), oq[k], eqq[k][rp[k] % 64]);
                  rp[k]++;
               end
            end
            if (xv[k] && yv[k] && xrdy[k]) begin
               if (cnt[k] == 0) cf[k] = conj;
               a  = longint'(xi_s);
               b  = longint'(xq_s);
               c  = longint'(yi_s);
               d  = longint'(yq_s);
               ti = cf[k] ? (a * c + b * d) : (a * c - b * d);
               tq = cf[k] ? (b * c - a * d) : (a * d + b * c);
               ai[k] += ti;
               aq[k] += tq;
               cnt[k]++;
               if (cnt[k] == len_of(k)) begin
                  eqi[k][wp[k] % 64] = ai[k];
                  eqq[k][wp[k] % 64] = aq[k];
                  wp[k]++;
                  ai[k]  = 0;
                  aq[k]  = 0;
                  cnt[k] = 0;
               end
            end
         end
      end
   end

   task automatic set_data(input int a, input int b, input int c, input int d, input bit cj);
      xi_s = 12'(a);
      xq_s = 12'(b);
      yi_s = 12'(c);
      yq_s = 12'(d);
      conj = cj;
   endtask

   task automatic beat(input int k, input int a, input int b, input int c, input int d,
                       input bit cj);
      bit got;
      got = 1'b0;
      set_data(a, b, c, d, cj);
      xv[k] = 1'b1;
      yv[k] = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         got = xrdy[k];
         @(posedge clk);
         #1;
         if (got) break;
      end
      check("beat_accepted", longint'(got), 1);
   endtask

   task automatic idle(input int k);
      xv[k] = 1'b0;
      yv[k] = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_result(input int k, input string tag, input longint ei,
                              input longint eq, output int n);
      n = 0;
      while (!tv[k] && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_tvalid"}, longint'(tv[k]), 1);
      check({tag, "_i"}, oi[k], ei);
      check({tag, "_q"}, oq[k], eq);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      xv    = '0;
      yv    = '0;
      ptr   = 3'b111;
      set_data(0, 0, 0, 0, 1'b0);
      #12;
      for (int k = 0; k < 3; k++) begin
         check("reset_tvalid", longint'(tv[k]), 0);
         check("reset_i", oi[k], 0);
         check("reset_q", oq[k], 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(2);
      check("idle_x_tready", longint'(xrdy[0]), 1);

      // conj=1, x=(1,2), y=(3,4) -> (44, 8), four edges after the last beat
      for (int b = 0; b < 4; b++) beat(0, 1, 2, 3, 4, 1'b1);
      idle(0);
      wait_result(0, "t1", 44, 8, n);
      check("t1_latency", longint'(n), 4);
      cycles(4);

      // back-to-back frames, conj toggling per frame but flipped on non-first beats
      for (int f = 0; f < 4; f++)
         for (int b = 0; b < 4; b++)
            beat(0, 1, 2, 3, 4, (b == 0) ? f[0] : ~f[0]);
      idle(0);
      cycles(8);

      // downstream stall while a result is pending
      ptr[0] = 1'b0;
      for (int b = 0; b < 4; b++) beat(0, 1, 2, 3, 4, 1'b1);
      idle(0);
      wait_result(0, "t3", 44, 8, n);
      set_data(5, -6, 7, 8, 1'b0);
      xv[0] = 1'b1;
      yv[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t3_hold_tvalid", longint'(tv[0]), 1);
         check("t3_hold_i", oi[0], 44);
         check("t3_hold_q", oq[0], 8);
         check("t3_x_tready", longint'(xrdy[0]), 0);
         check("t3_y_tready", longint'(yrdy[0]), 0);
      end
      @(posedge clk);
      #1;
      ptr[0] = 1'b1;
      for (int b = 0; b < 4; b++) beat(0, 5, -6, 7, 8, 1'b0);
      idle(0);
      cycles(8);

      // lone x valid consumes nothing
      set_data(1, 2, 3, 4, 1'b0);
      xv[0] = 1'b1;
      yv[0] = 1'b0;
      cycles(5);
      for (int b = 0; b < 4; b++) beat(0, 1, 2, 3, 4, 1'b0);
      idle(0);
      wait_result(0, "t4", -20, 40, n);
      cycles(4);

      // reset mid-frame discards the partial sum
      beat(0, 100, -200, 300, 400, 1'b0);
      beat(0, -700, 50, 9, 1000, 1'b0);
      idle(0);
      rst_n = 1'b0;
      #1;
      check("t5_reset_tvalid", longint'(tv[0]), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int b = 0; b < 4; b++) beat(0, 1, 0, 1, 0, 1'b0);
      idle(0);
      wait_result(0, "t5", 4, 0, n);
      cycles(4);

      // full-scale corner on the LENGTH=64 instance
      for (int b = 0; b < 64; b++) beat(1, -2048, -2048, -2048, -2048, 1'b0);
      idle(1);
      wait_result(1, "t6", 0, 536870912, n);
      cycles(4);

      // LENGTH=1: result every beat, tvalid held high across handshakes
      for (int b = 0; b < 12; b++) begin
         beat(2, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
              1'($urandom));
         if (b >= 4) check("t7_stream_tvalid", longint'(tv[2]), 1);
      end
      idle(2);
      cycles(8);

      // random valids, data, conj and downstream ready on all instances
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         xi_s = 12'($urandom);
         xq_s = 12'($urandom);
         yi_s = 12'($urandom);
         yq_s = 12'($urandom);
         conj = 1'($urandom);
         for (int k = 0; k < 3; k++) begin
            xv[k]  = ($urandom % 4) != 0;
            yv[k]  = ($urandom % 4) != 0;
            ptr[k] = ($urandom % 4) != 0;
         end
      end
      xv  = '0;
      yv  = '0;
      ptr = 3'b111;
      cycles(12);
      for (int k = 0; k < 3; k++)
         check($sformatf("drain_len%0d", len_of(k)), longint'(rp[k]), longint'(wp[k]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
